// File: rtl/shift_mult16_seq.sv
// shift_mult16_seq: posedge sequencer wrapped around a 16-bit serial shift
// multiplier whose datapath steps on negedge, one step per operand-b bit.
//
// Operation:
//   - Accepts an operand pair on an in_valid/in_ready handshake.
//   - Holds the operands on mult_a/mult_b and strobes mult_rst so the
//     multiplier loads.
//   - Releases mult_rst for exactly B_WIDTH cycles, then captures mult_y.
//   - Offers the captured result on an out_valid/out_ready handshake.
//
// Optional build macro: SHIFT_MULT16_SEQ_ZERO_SKIP_EN. When it is defined, an
// accepted pair with a zero operand goes straight to DONE with a zero result.
module shift_mult16_seq #(
    parameter int B_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_a,
    input  logic [B_WIDTH-1:0] in_b,
    output logic               mult_rst,
    output logic [15:0]        mult_a,
    output logic [B_WIDTH-1:0] mult_b,
    input  logic [15:0]        mult_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_y,
    output logic               busy
);

    // One extra bit of headroom so the counter never wraps inside RUN.
    localparam int CW = $clog2(B_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(B_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    logic            accept;

`ifdef SHIFT_MULT16_SEQ_ZERO_SKIP_EN
    logic            zero_op;
    assign zero_op = (in_a == 16'd0) || (in_b == '0);
`endif

    // in_ready is the only combinational output: accept only while idle.
    assign in_ready = (state_reg == IDLE);
    assign accept   = in_valid && in_ready;

    // Sequencer: handshake, multiplier strobe, step counting and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            mult_rst  <= 1'b1;
            mult_a    <= '0;
            mult_b    <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mult_rst <= 1'b1;
                    if (accept) begin
                        mult_a <= in_a;
                        mult_b <= in_b;
                        busy   <= 1'b1;
`ifdef SHIFT_MULT16_SEQ_ZERO_SKIP_EN
                        if (zero_op) begin
                            // Product is trivially zero; the multiplier stays cleared.
                            out_y     <= '0;
                            out_valid <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= LOAD;
                        end
`else
                        state_reg <= LOAD;
`endif
                    end
                end
                LOAD: begin
                    // The multiplier loaded mult_b on the negedge inside this cycle.
                    mult_rst  <= 1'b0;
                    count_reg <= '0;
                    state_reg <= RUN;
                end
                RUN: begin
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_STEP) begin
                        // The last serial step completed on the preceding negedge.
                        out_y     <= mult_y;
                        out_valid <= 1'b1;
                        mult_rst  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    mult_rst  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_mult16_seq.sv
// Testbench for shift_mult16_seq.
//
// Two instances are exercised:
//   - B_WIDTH=8, the default build.
//   - B_WIDTH=4.
//
// Each instance drives a behavioural negedge serial shift-add multiplier.
// Latencies are counted with the accept edge as edge number 1.
// Under that count, out_valid rising on the 10th edge gives latency 10.
`timescale 1ns/1ps
module tb_shift_mult16_seq;

`ifdef SHIFT_MULT16_SEQ_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [7:0]  in_b;
    logic        out_ready;
    logic        sel;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire in_valid0 = in_valid & ~sel;
    wire in_valid1 = in_valid & sel;

    logic        in_ready0, mult_rst0, out_valid0, busy0;
    logic [15:0] mult_a0, mult_y0, out_y0;
    logic [7:0]  mult_b0;
    logic        in_ready1, mult_rst1, out_valid1, busy1;
    logic [15:0] mult_a1, mult_y1, out_y1;
    logic [3:0]  mult_b1;

    shift_mult16_seq #(.B_WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .mult_rst(mult_rst0), .mult_a(mult_a0),
        .mult_b(mult_b0), .mult_y(mult_y0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_y(out_y0), .busy(busy0)
    );

    shift_mult16_seq #(.B_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b[3:0]), .mult_rst(mult_rst1), .mult_a(mult_a1),
        .mult_b(mult_b1), .mult_y(mult_y1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_y(out_y1), .busy(busy1)
    );

    // Serial multipliers: load on mult_rst, otherwise acc=(acc+(b0?a:0))>>1.
    logic [15:0] acc0, acc1;
    logic [7:0]  br0;
    logic [3:0]  br1;
    always @(negedge clk) begin
        if (mult_rst0) begin
            acc0 <= 16'd0;
            br0  <= mult_b0;
        end else begin
            acc0 <= 16'(({1'b0, acc0} + (br0[0] ? {1'b0, mult_a0} : 17'd0)) >> 1);
            br0  <= br0 >> 1;
        end
        if (mult_rst1) begin
            acc1 <= 16'd0;
            br1  <= mult_b1;
        end else begin
            acc1 <= 16'(({1'b0, acc1} + (br1[0] ? {1'b0, mult_a1} : 17'd0)) >> 1);
            br1  <= br1 >> 1;
        end
    end
    assign mult_y0 = acc0;
    assign mult_y1 = acc1;

    // View of whichever instance is currently selected.
    wire        cur_in_ready  = sel ? in_ready1  : in_ready0;
    wire        cur_out_valid = sel ? out_valid1 : out_valid0;
    wire        cur_mult_rst  = sel ? mult_rst1  : mult_rst0;
    wire        cur_busy      = sel ? busy1      : busy0;
    wire [15:0] cur_out_y     = sel ? out_y1     : out_y0;
    wire [15:0] cur_mult_a    = sel ? mult_a1    : mult_a0;
    wire [7:0]  cur_mult_b    = sel ? {4'b0, mult_b1} : mult_b0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic        sel;
        logic [15:0] y;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[8];
    vec_t bb[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int n;
        int low;
        int unstable;
        int held_err;
        sel = v.sel;
        out_ready = (v.hold == 0);
        #1;
        n = 0;
        while (!cur_in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(cur_in_ready), 32'd1);
        in_a = v.a;
        in_b = v.b;
        in_valid = 1'b1;
        tick();                                   // accept edge (edge 1)
        in_valid = 1'b0;
        in_a = ~v.a;                              // must not disturb the held operands
        in_b = ~v.b;
        n = 1;
        low = 0;
        unstable = 0;
        while (!cur_out_valid && n < 40) begin
            if (!cur_mult_rst) low++;
            if (cur_mult_a !== v.a || cur_mult_b !== v.b) unstable++;
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(v.lat));
        check({tag, "_rstlow"}, 32'(low), 32'((v.lat > 1) ? v.lat - 2 : 0));
        check({tag, "_opstable"}, 32'(unstable), 32'd0);
        check({tag, "_mult_a"}, 32'(cur_mult_a), 32'(v.a));
        check({tag, "_y"}, 32'(cur_out_y), 32'(v.y));
        check({tag, "_busy"}, {30'd0, cur_busy, cur_in_ready}, 32'b10);
        held_err = 0;
        for (int k = 0; k < v.hold; k++) begin
            tick();
            if (cur_out_y !== v.y || !cur_out_valid || cur_in_ready) held_err++;
        end
        if (v.hold > 0) check({tag, "_hold"}, 32'(held_err), 32'd0);
        out_ready = 1'b1;
        tick();                                   // DONE exit edge
        check({tag, "_exit"}, {29'd0, cur_out_valid, cur_in_ready, cur_busy}, 32'b010);
        $display("op %s a=%h b=%h y=%h lat=%0d", tag, v.a, v.b, cur_out_y, n);
    endtask

    initial begin
        int acc_cyc;
        int prev_cyc;
        int n;

        vecs[0] = '{16'h8000, 8'h80, 1'b0, 16'h4000, 10, 0};
        vecs[1] = '{16'h1234, 8'h01, 1'b0, 16'h0012, 10, 5};
        vecs[2] = '{16'hFFFF, 8'h00, 1'b0, 16'h0000, ZLAT, 0};
        vecs[3] = '{16'hFFFF, 8'hFF, 1'b0, 16'hFEFF, 10, 0};
        vecs[4] = '{16'h1234, 8'h56, 1'b0, 16'h061D, 10, 0};
        vecs[5] = '{16'h00FF, 8'hFF, 1'b0, 16'h00FE, 10, 0};
        vecs[6] = '{16'hFFFF, 8'h0F, 1'b1, 16'hEFFF, 6, 0};
        vecs[7] = '{16'h1000, 8'h08, 1'b1, 16'h0800, 6, 0};
        bb[0]   = '{16'hABCD, 8'h02, 1'b0, 16'h0157, 10, 0};
        bb[1]   = '{16'h0001, 8'hFF, 1'b0, 16'h0000, 10, 0};
        bb[2]   = '{16'h00FF, 8'hFF, 1'b0, 16'h00FE, 10, 0};
        bb[3]   = '{16'h8000, 8'h80, 1'b0, 16'h4000, 10, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 16'h5A5A;
        in_b = 8'hA5;
        out_ready = 1'b1;
        sel = 1'b0;
        repeat (3) tick();
        check("reset_state", {26'd0, cur_in_ready, cur_mult_rst, cur_out_valid, cur_busy, 2'b00}, 32'b110000);
        check("reset_y", 32'(cur_out_y), 32'd0);
        check("reset_ab", {8'd0, cur_mult_a, cur_mult_b}, 32'd0);
        rst = 1'b0;
        tick();

        // Directed vector table.
        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("v%0d", i));

        // Back-to-back operations with in_valid held high.
        sel = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            in_a = bb[k].a;
            in_b = bb[k].b;
            n = 0;
            while (!cur_in_ready && n < 50) begin
                tick();
                n++;
            end
            acc_cyc = cyc;
            tick();                               // accept edge
            in_a = 16'hDEAD ^ 16'(k);
            in_b = 8'h3C ^ 8'(k);
            if (k > 0) check($sformatf("b2b%0d_period", k), 32'(acc_cyc - prev_cyc), 32'd11);
            prev_cyc = acc_cyc;
            n = 1;
            while (!cur_out_valid && n < 40) begin
                tick();
                n++;
            end
            check($sformatf("b2b%0d_y", k), 32'(cur_out_y), 32'(bb[k].y));
            $display("op b2b%0d a=%h b=%h y=%h lat=%0d", k, bb[k].a, bb[k].b, cur_out_y, n);
            tick();                               // DONE exit edge
        end
        in_valid = 1'b0;
        tick();

        // Reset in the middle of RUN, then a clean operation.
        sel = 1'b0;
        in_a = 16'h1234;
        in_b = 8'h56;
        in_valid = 1'b1;
        tick();                                   // accept
        in_valid = 1'b0;
        repeat (4) tick();                        // LOAD, then RUN with counter at 3
        check("midrun_running", {30'd0, cur_mult_rst, cur_busy}, 32'b01);
        rst = 1'b1;
        #1;
        check("midrun_reset", {28'd0, cur_out_valid, cur_mult_rst, cur_in_ready, cur_busy}, 32'b0110);
        check("midrun_reset_y", 32'(cur_out_y), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        run_op(vecs[4], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
